// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART receiver: 16x oversampling, majority-vote sampling, optional parity
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-high
//   rx             serial line, idle high, asynchronous to clock
//   baud_rate      00=2400 01=4800 10=9600 11=19200, latched at start edge
//   parity_type    00=none 01=odd 10=even 11=none, latched at start edge
//   data_out       last received byte
//   rx_active_flag high while a frame is in progress
//   rx_done_flag   one-cycle pulse per completed (or aborted-at-start) frame
//   error_flag     [0] parity, [1] start bit, [2] stop/framing
module uart_rx_frame #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  input  logic [1:0] baud_rate,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       rx_active_flag,
  output logic       rx_done_flag,
  output logic [2:0] error_flag
);

  // Divisors rounded to nearest; at 50 MHz these give 1302/651/326/163.
  localparam int HALF      = OVERSAMPLE / 2;
  localparam int DIV_2400  = (CLK_FREQ + 2400 * HALF) / (2400 * OVERSAMPLE);
  localparam int DIV_4800  = (CLK_FREQ + 4800 * HALF) / (4800 * OVERSAMPLE);
  localparam int DIV_9600  = (CLK_FREQ + 9600 * HALF) / (9600 * OVERSAMPLE);
  localparam int DIV_19200 = (CLK_FREQ + 19200 * HALF) / (19200 * OVERSAMPLE);
  localparam int DIV_W     = (DIV_2400 > 2) ? $clog2(DIV_2400) : 1;

  localparam logic [DIV_W-1:0] DM1_2400  = DIV_W'(DIV_2400 - 1);
  localparam logic [DIV_W-1:0] DM1_4800  = DIV_W'(DIV_4800 - 1);
  localparam logic [DIV_W-1:0] DM1_9600  = DIV_W'(DIV_9600 - 1);
  localparam logic [DIV_W-1:0] DM1_19200 = DIV_W'(DIV_19200 - 1);
  localparam logic [3:0]       LAST_SAMPLE = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_nxt;
  logic             rx_meta, rx_s, rx_prev;
  logic [DIV_W-1:0] div_cnt, div_m1;
  logic [3:0]       sample_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             s7, s8;
  logic [1:0]       baud_l, par_l;

  logic start_edge, tick, decide, maj, par_en, par_bad;
  logic shift_en, load_out, done_nxt, err_start, err_par, err_stop;

  // Sync flops reset high so that leaving reset on an idle line is not a start edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_comb begin
    div_m1 = DM1_2400;
    case (baud_l)
      2'b00:   div_m1 = DM1_2400;
      2'b01:   div_m1 = DM1_4800;
      2'b10:   div_m1 = DM1_9600;
      default: div_m1 = DM1_19200;
    endcase
  end

  assign start_edge = (state == IDLE) && rx_prev && !rx_s;
  assign tick       = (state != IDLE) && (div_cnt == div_m1);
  // sample_cnt holds the number of ticks already seen in the bit, so the
  // tick taken while it reads 8 is the 9th tick: the decision point.
  assign decide     = tick && (sample_cnt == 4'd8);
  assign maj        = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
  assign par_en     = (par_l == 2'b01) || (par_l == 2'b10);
  assign par_bad    = ((^shift_reg) ^ maj) != (par_l == 2'b01);

  assign rx_active_flag = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Every transition happens at the mid-bit decision tick; the sample
  // counter keeps running, so the next bit's decision stays aligned.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    load_out  = 1'b0;
    done_nxt  = 1'b0;
    err_start = 1'b0;
    err_par   = 1'b0;
    err_stop  = 1'b0;
    case (state)
      IDLE: if (start_edge) state_nxt = START;
      START: if (decide) begin
        if (maj) begin
          err_start = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = DATA;
        end
      end
      DATA: if (decide) begin
        shift_en = 1'b1;
        if (bit_cnt == 3'd7) state_nxt = par_en ? PARITY : STOP;
      end
      PARITY: if (decide) begin
        err_par   = par_bad;
        state_nxt = STOP;
      end
      STOP: if (decide) begin
        err_stop  = ~maj;
        load_out  = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt      <= '0;
      sample_cnt   <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      s7           <= 1'b0;
      s8           <= 1'b0;
      baud_l       <= '0;
      par_l        <= '0;
      data_out     <= '0;
      rx_done_flag <= 1'b0;
      error_flag   <= '0;
    end else begin
      rx_done_flag <= done_nxt;

      if (state == IDLE) begin
        div_cnt    <= '0;
        sample_cnt <= '0;
        bit_cnt    <= '0;
      end else if (tick) begin
        div_cnt    <= '0;
        sample_cnt <= (sample_cnt == LAST_SAMPLE) ? 4'd0 : sample_cnt + 4'd1;
        if (sample_cnt == 4'd6) s7 <= rx_s;
        if (sample_cnt == 4'd7) s8 <= rx_s;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (shift_en) begin
        shift_reg <= {maj, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end

      if (start_edge) begin
        baud_l     <= baud_rate;
        par_l      <= parity_type;
        error_flag <= '0;
      end else begin
        error_flag <= error_flag | {err_stop, err_start, err_par};
      end

      if (load_out) data_out <= shift_reg;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - scoreboard bench for uart_rx_frame
module tb_uart_rx_frame;

  typedef struct {
    logic [7:0] data;
    logic [2:0] err;
    int         start;
    int         lat;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rx_full = 1'b1;
  logic [1:0] baud_rate = 2'b11;
  logic [1:0] parity_type = 2'b00;
  logic [1:0] baud_full = 2'b11;

  logic [7:0] data_out, data_full;
  logic       rx_active_flag, active_full;
  logic       rx_done_flag, done_full;
  logic [2:0] error_flag, err_full;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];
  exp_t sbq_full[$];

  // Scaled clock rate gives divisors 32/16/8/4 so full frames stay short.
  uart_rx_frame #(.CLK_FREQ(1_228_800)) dut (
    .clock(clock), .reset(reset), .rx(rx), .baud_rate(baud_rate),
    .parity_type(parity_type), .data_out(data_out),
    .rx_active_flag(rx_active_flag), .rx_done_flag(rx_done_flag),
    .error_flag(error_flag)
  );

  // Default 50 MHz instance: exercises the real divisors via start-bit rejection.
  uart_rx_frame dut_full (
    .clock(clock), .reset(reset), .rx(rx_full), .baud_rate(baud_full),
    .parity_type(2'b00), .data_out(data_full),
    .rx_active_flag(active_full), .rx_done_flag(done_full),
    .error_flag(err_full)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int div_s(input logic [1:0] b);
    case (b)
      2'b00:   return 32;
      2'b01:   return 16;
      2'b10:   return 8;
      default: return 4;
    endcase
  endfunction

  function automatic int div_f(input logic [1:0] b);
    case (b)
      2'b00:   return 1302;
      2'b01:   return 651;
      2'b10:   return 326;
      default: return 163;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input int act, input int exp);
    checks++;
    if (act < exp - 1 || act > exp + 1) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d(+-1)", name, act, exp);
    end
  endtask

  task automatic check_done(input string tag, input exp_t e, input logic [7:0] d,
                            input logic [2:0] er, input logic act);
    chk({tag, "_data"}, int'(d), int'(e.data));
    chk({tag, "_error_flag"}, int'(er), int'(e.err));
    chk({tag, "_active_low_at_done"}, int'(act), 0);
    chk_near({tag, "_latency"}, cyc - e.start, e.lat);
  endtask

  // Monitor: every rx_done_flag pulse consumes exactly one expected entry.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && rx_done_flag) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done data=%0h err=%0h", data_out, error_flag);
      end else begin
        e = sbq.pop_front();
        check_done("frame", e, data_out, error_flag, rx_active_flag);
      end
    end
    if (!reset && done_full) begin
      if (sbq_full.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done_full data=%0h err=%0h", data_full, err_full);
      end else begin
        e = sbq_full.pop_front();
        check_done("full", e, data_full, err_full, active_full);
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic [1:0] b, input logic [1:0] p,
                            input logic par_bit, input logic stop_bit, input logic [2:0] exp_err);
    exp_t e;
    int   bc;
    bc = 16 * div_s(b);
    baud_rate   = b;
    parity_type = p;
    rx          = 1'b0;
    e.data  = d;
    e.err   = exp_err;
    e.start = cyc;
    e.lat   = 3 + (((p == 2'b01) || (p == 2'b10)) ? 169 : 153) * div_s(b);
    sbq.push_back(e);
    repeat (4) @(negedge clock);
    chk("active_after_start", int'(rx_active_flag), 1);
    chk("error_cleared_on_start", int'(error_flag), 0);
    // Settings are latched at the start edge; disturbing them must not matter.
    baud_rate   = ~b;
    parity_type = ~p;
    repeat (bc - 4) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (bc) @(negedge clock);
    end
    if ((p == 2'b01) || (p == 2'b10)) begin
      rx = par_bit;
      repeat (bc) @(negedge clock);
    end
    rx = stop_bit;
    repeat (bc) @(negedge clock);
  endtask

  task automatic glitch(input logic [7:0] held_data);
    exp_t e;
    baud_rate = 2'b11;
    rx        = 1'b0;
    e.data  = held_data;
    e.err   = 3'b010;
    e.start = cyc;
    e.lat   = 3 + 9 * 4;
    sbq.push_back(e);
    repeat (3 * 4) @(negedge clock);
    rx = 1'b1;
    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clock);
    repeat (8) @(negedge clock);
  endtask

  task automatic glitch_full(input logic [1:0] b);
    exp_t e;
    int   d;
    d = div_f(b);
    baud_full = b;
    rx_full   = 1'b0;
    e.data  = 8'h00;
    e.err   = 3'b010;
    e.start = cyc;
    e.lat   = 3 + 9 * d;
    sbq_full.push_back(e);
    repeat (3 * d) @(negedge clock);
    rx_full = 1'b1;
    for (int i = 0; i < 10 * d && sbq_full.size() != 0; i++) @(negedge clock);
    repeat (8) @(negedge clock);
  endtask

  initial begin
    logic [7:0] partial;

    repeat (4) @(negedge clock);
    chk("reset_data_out", int'(data_out), 0);
    chk("reset_active", int'(rx_active_flag), 0);
    chk("reset_done", int'(rx_done_flag), 0);
    chk("reset_error_flag", int'(error_flag), 0);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    chk("idle_active", int'(rx_active_flag), 0);
    chk("idle_full_active", int'(active_full), 0);

    // 19200 odd parity, 0xAA with correct parity 1
    send_frame(8'hAA, 2'b11, 2'b01, 1'b1, 1'b1, 3'b000);
    repeat (20) @(negedge clock);

    // 9600 back-to-back, second frame uses parity code 11 (none)
    send_frame(8'h55, 2'b10, 2'b00, 1'b0, 1'b1, 3'b000);
    send_frame(8'h0F, 2'b10, 2'b11, 1'b0, 1'b1, 3'b000);
    repeat (20) @(negedge clock);

    // 19200 even parity, 0x01 with wrong parity bit 0
    send_frame(8'h01, 2'b11, 2'b10, 1'b0, 1'b1, 3'b001);
    repeat (20) @(negedge clock);

    // 2400 framing error, then a clean 4800 frame clears the flag at start
    send_frame(8'hC3, 2'b00, 2'b00, 1'b0, 1'b0, 3'b100);
    rx = 1'b1;
    repeat (512) @(negedge clock);
    chk("framing_error_holds", int'(error_flag), 3'b100);
    send_frame(8'h96, 2'b01, 2'b00, 1'b0, 1'b1, 3'b000);
    repeat (20) @(negedge clock);

    // short low pulse rejected at start; data_out keeps 0x96
    glitch(8'h96);

    // real divisors on the 50 MHz instance
    glitch_full(2'b11);
    glitch_full(2'b10);
    glitch_full(2'b01);
    glitch_full(2'b00);

    // reset in the middle of bit 4 of a 0x3C frame
    partial     = 8'h3C;
    baud_rate   = 2'b11;
    parity_type = 2'b00;
    rx          = 1'b0;
    repeat (64) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      rx = partial[i];
      repeat ((i == 4) ? 32 : 64) @(negedge clock);
    end
    reset = 1'b1;
    #1;
    chk("midframe_reset_data_out", int'(data_out), 0);
    chk("midframe_reset_active", int'(rx_active_flag), 0);
    chk("midframe_reset_error_flag", int'(error_flag), 0);
    chk("midframe_reset_done", int'(rx_done_flag), 0);
    @(negedge clock);
    reset = 1'b0;
    rx    = 1'b1;
    repeat (256) @(negedge clock);
    chk("after_reset_idle", int'(rx_active_flag), 0);
    send_frame(8'h3C, 2'b11, 2'b00, 1'b0, 1'b1, 3'b000);

    for (int i = 0; i < 2000 && (sbq.size() != 0 || sbq_full.size() != 0); i++)
      @(negedge clock);
    chk("scoreboard_drained", sbq.size(), 0);
    chk("scoreboard_full_drained", sbq_full.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
